dcache_tag_ctrl: RTL and testbench

Initiator-side controller for the 16-set x 24-bit single-port data-cache tag SRAM. It accepts lookup and update requests from the dcache pipeline, drives the SRAM chip-select, write-enable, address and data lines, and compares the returned entry against the requested tag. It also runs a full-array invalidation sweep, on demand and optionally after reset. It sits between the dcache FSM and the tag SRAM macro, and is the only agent on that SRAM port.

---
 rtl/dcache_tag_ctrl_if.sv | 27 ++
 rtl/dcache_tag_ctrl.sv | 100 ++++++++++
 tb/tb_dcache_tag_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_tag_ctrl_if.sv
// Request/response channel between the dcache pipeline (master) and the tag controller (slave).
interface dcache_tag_ctrl_if #(
    parameter int unsigned SET_W = 4,
    parameter int unsigned TAG_W = 22
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [SET_W-1:0] req_set;
    logic [TAG_W-1:0] req_tag;
    logic             req_dirty;
    logic             resp_valid;
    logic             resp_write;
    logic             resp_hit;
    logic             resp_dirty;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_write, req_set, req_tag, req_dirty,
        input  req_ready, resp_valid, resp_write, resp_hit, resp_dirty, resp_tag
    );

    modport slave (
        input  req_valid, req_write, req_set, req_tag, req_dirty,
        output req_ready, resp_valid, resp_write, resp_hit, resp_dirty, resp_tag
    );
endinterface

// File: rtl/dcache_tag_ctrl.sv
// Tag SRAM controller: lookup/update with one-cycle response plus full-array invalidation sweep.
// Define DCACHE_TAG_INIT_SWEEP_EN to run the invalidation sweep automatically out of reset.
module dcache_tag_ctrl #(
    parameter int unsigned SETS  = 16,
    parameter int unsigned SET_W = 4,
    parameter int unsigned TAG_W = 22
) (
    input  logic               clk,
    input  logic               rst,
    dcache_tag_ctrl_if.slave   bus,
    input  logic               inv_all,
    output logic               busy,
    output logic               sram_csb,
    output logic               sram_web,
    output logic [SET_W-1:0]   sram_addr,
    output logic [TAG_W+1:0]   sram_din,
    input  logic [TAG_W+1:0]   sram_dout
);
    localparam int unsigned WORD_W = TAG_W + 2;

    typedef enum logic {
        RUN,
        SWEEP
    } state_t;

`ifdef DCACHE_TAG_INIT_SWEEP_EN
    localparam state_t RST_STATE = SWEEP;
`else
    localparam state_t RST_STATE = RUN;
`endif

    state_t           state;
    logic [SET_W-1:0] cnt;
    logic             pend_valid;
    logic             pend_write;
    logic [TAG_W-1:0] pend_tag;
    logic             accept;
    logic             lookup;

    assign accept = bus.req_valid && bus.req_ready;

    // State, sweep counter and the pending-response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RST_STATE;
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend_write <= 1'b0;
            pend_tag   <= '0;
        end else begin
            pend_valid <= accept;
            if (accept) begin
                pend_write <= bus.req_write;
                pend_tag   <= bus.req_tag;
            end
            case (state)
                RUN: begin
                    if (inv_all) state <= SWEEP;
                end
                SWEEP: begin
                    cnt <= cnt + SET_W'(1);
                    if (cnt == SET_W'(SETS - 1)) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // SRAM port is driven in the accept cycle so the read data lines up with the pending register.
    always_comb begin
        bus.req_ready = 1'b0;
        sram_csb      = 1'b1;
        sram_web      = 1'b1;
        sram_addr     = '0;
        sram_din      = '0;
        if (!rst) begin
            if (state == SWEEP) begin
                sram_csb  = 1'b0;
                sram_web  = 1'b0;
                sram_addr = cnt;
            end else begin
                bus.req_ready = !inv_all;
                if (bus.req_valid && !inv_all) begin
                    sram_csb  = 1'b0;
                    sram_web  = !bus.req_write;
                    sram_addr = bus.req_set;
                    sram_din  = WORD_W'({1'b1, bus.req_dirty, bus.req_tag});
                end
            end
        end
    end

    assign lookup         = pend_valid && !pend_write;
    assign busy           = (state == SWEEP);
    assign bus.resp_valid = pend_valid;
    assign bus.resp_write = pend_valid && pend_write;
    assign bus.resp_hit   = lookup && sram_dout[TAG_W+1] && (sram_dout[TAG_W-1:0] == pend_tag);
    assign bus.resp_dirty = lookup && sram_dout[TAG_W];
    assign bus.resp_tag   = lookup ? sram_dout[TAG_W-1:0] : '0;
endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Bench for dcache_tag_ctrl: directed vector table, multi-cycle corner sequences, random traffic vs a reference model.
module tb_dcache_tag_ctrl;
    localparam int unsigned SETS = 16;

`ifdef DCACHE_TAG_INIT_SWEEP_EN
    localparam bit INIT_SWEEP = 1'b1;
`else
    localparam bit INIT_SWEEP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inv_all;
    logic        busy;
    logic        sram_csb, sram_web;
    logic [3:0]  sram_addr;
    logic [23:0] sram_din, sram_dout;

    dcache_tag_ctrl_if bus ();

    dcache_tag_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .inv_all   (inv_all),
        .busy      (busy),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] init_word(input int i);
        logic [31:0] v;
        v = 32'(i) * 32'h0001_3579 + 32'h0000_0101;
        return {1'b1, v[0], v[21:0]};
    endfunction

    // Tag SRAM macro: inputs registered on the edge, writes land one edge later, read data is
    // combinational from the registered address.
    logic [23:0] mem [SETS];
    logic [3:0]  ram_addr_r = '0;
    logic        ram_wr_pend = 1'b0;
    logic [3:0]  ram_wr_addr = '0;
    logic [23:0] ram_wr_data = '0;
    logic        mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < SETS; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (ram_wr_pend) begin
            mem[ram_wr_addr] <= ram_wr_data;
        end
        ram_wr_pend <= !sram_csb && !sram_web;
        if (!sram_csb) begin
            if (!sram_web) begin
                ram_wr_addr <= sram_addr;
                ram_wr_data <= sram_din;
            end else begin
                ram_addr_r <= sram_addr;
            end
        end
    end
    assign sram_dout = mem[ram_addr_r];

    // Reference model: array contents as the pipeline would see them, plus the one outstanding response.
    logic [23:0] mmem [SETS];
    int          sweep_left;
    bit          have_pend;
    bit          p_write, p_hit, p_dirty;
    logic [21:0] p_tag;

    int n_total = 0, n_pass = 0;
    int ready_low = 0, lkp_resp = 0, lkp_hit = 0, busy_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic v, input logic w, input logic [3:0] s,
                        input logic [21:0] t, input logic d, input logic inv);
        bit          exp_ready, acc;
        logic [23:0] e;
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = v; bus.req_write = w; bus.req_set = s;
        bus.req_tag = t;   bus.req_dirty = d; inv_all = inv;
        #1;
        exp_ready = (sweep_left == 0) && !inv;
        acc = v && exp_ready;
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(sweep_left > 0));
        if (sweep_left > 0) begin
            check("sweep_csb",  32'(sram_csb), 32'(0));
            check("sweep_web",  32'(sram_web), 32'(0));
            check("sweep_addr", 32'(sram_addr), 32'(SETS - sweep_left));
            check("sweep_din",  32'(sram_din), 32'(0));
        end else if (acc) begin
            check("acc_csb",  32'(sram_csb), 32'(0));
            check("acc_web",  32'(sram_web), 32'(!w));
            check("acc_addr", 32'(sram_addr), 32'(s));
            check("acc_din",  32'(sram_din), 32'({1'b1, d, t}));
        end else begin
            check("idle_csb",  32'(sram_csb), 32'(1));
            check("idle_web",  32'(sram_web), 32'(1));
            check("idle_addr", 32'(sram_addr), 32'(0));
            check("idle_din",  32'(sram_din), 32'(0));
        end
        check("resp_valid", 32'(bus.resp_valid), 32'(have_pend));
        if (have_pend) begin
            check("resp_write", 32'(bus.resp_write), 32'(p_write));
            check("resp_hit",   32'(bus.resp_hit), 32'(!p_write && p_hit));
            if (!p_write) begin
                check("resp_dirty", 32'(bus.resp_dirty), 32'(p_dirty));
                check("resp_tag",   32'(bus.resp_tag), 32'(p_tag));
            end
        end else begin
            check("quiet_resp", 32'({bus.resp_write, bus.resp_hit, bus.resp_dirty, bus.resp_tag}), 32'(0));
        end
        if (!bus.req_ready) ready_low++;
        if (busy) busy_cyc++;
        if (bus.resp_valid && !bus.resp_write) begin
            lkp_resp++;
            if (bus.resp_hit) lkp_hit++;
        end
        // Advance the model to the state after the coming edge.
        if (sweep_left > 0) begin
            mmem[SETS - sweep_left] = '0;
            sweep_left--;
        end else if (inv) begin
            sweep_left = SETS;
        end
        if (acc) begin
            p_write = w;
            if (w) begin
                mmem[s] = {1'b1, d, t};
            end else begin
                e = mmem[s];
                p_hit = e[23] && (e[21:0] == t);
                p_dirty = e[22];
                p_tag = e[21:0];
            end
        end
        have_pend = acc;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1; bus.req_valid = 1'b0; inv_all = 1'b0;
            #1;
            check("rst_csb", 32'(sram_csb), 32'(1));
            if (i > 0) check("rst_resp_valid", 32'(bus.resp_valid), 32'(0));
        end
        have_pend = 1'b0;
        sweep_left = INIT_SWEEP ? SETS : 0;
    endtask

    typedef struct {
        logic        v, w;
        logic [3:0]  s;
        logic [21:0] t;
        logic        d, chk;
        logic        e_valid, e_write, e_hit, e_dirty;
        logic [21:0] e_tag;
    } vec_t;

    vec_t vecs [7];
    logic [21:0] pool [4];

    initial begin
        vecs[0] = '{1, 1, 4'd3, 22'h2ABCDE, 1, 0, 0, 0, 0, 0, 22'h0};
        vecs[1] = '{1, 0, 4'd3, 22'h2ABCDE, 0, 1, 1, 1, 0, 0, 22'h0};
        vecs[2] = '{1, 0, 4'd3, 22'h000001, 0, 1, 1, 0, 1, 1, 22'h2ABCDE};
        vecs[3] = '{1, 1, 4'd7, 22'h3FFFFF, 0, 1, 1, 0, 0, 1, 22'h2ABCDE};
        vecs[4] = '{1, 0, 4'd7, 22'h3FFFFF, 0, 1, 1, 1, 0, 0, 22'h0};
        vecs[5] = '{0, 0, 4'd0, 22'h0,      0, 1, 1, 0, 1, 0, 22'h3FFFFF};
        vecs[6] = '{0, 0, 4'd0, 22'h0,      0, 1, 0, 0, 0, 0, 22'h0};
        pool[0] = 22'h2ABCDE; pool[1] = 22'h0; pool[2] = 22'h3FFFFF; pool[3] = 22'h155555;
        for (int i = 0; i < SETS; i++) mmem[i] = init_word(i);
        have_pend = 1'b0; sweep_left = 0;
        rst = 1'b1; inv_all = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_set = '0;
        bus.req_tag = '0; bus.req_dirty = 1'b0;
        do_reset(3);

        if (INIT_SWEEP) begin
            busy_cyc = 0;
            for (int i = 0; i < SETS; i++) step(0, 0, 4'd0, 22'h0, 0, 0);
            check("init_busy_cycles", 32'(busy_cyc), 32'(SETS));
            step(1, 0, 4'd5, 22'h0, 0, 0);
            step(0, 0, 4'd0, 22'h0, 0, 0);
            check("init_lookup_miss", 32'(bus.resp_hit), 32'(0));
        end

        for (int i = 0; i < 7; i++) begin
            step(vecs[i].v, vecs[i].w, vecs[i].s, vecs[i].t, vecs[i].d, 0);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_valid", i), 32'(bus.resp_valid), 32'(vecs[i].e_valid));
                check($sformatf("vec%0d_write", i), 32'(bus.resp_write), 32'(vecs[i].e_write));
                check($sformatf("vec%0d_hit", i),   32'(bus.resp_hit),   32'(vecs[i].e_hit));
                check($sformatf("vec%0d_dirty", i), 32'(bus.resp_dirty), 32'(vecs[i].e_dirty));
                check($sformatf("vec%0d_tag", i),   32'(bus.resp_tag),   32'(vecs[i].e_tag));
            end
        end

        // Back-to-back updates then lookups of every set.
        for (int i = 0; i < SETS; i++) step(1, 1, 4'(i), 22'(i * 32'h11111 + 5), 1'(i), 0);
        lkp_resp = 0; lkp_hit = 0;
        for (int i = 0; i < SETS; i++) step(1, 0, 4'(i), 22'(i * 32'h11111 + 5), 0, 0);
        step(0, 0, 4'd0, 22'h0, 0, 0);
        check("b2b_pulses", 32'(lkp_resp), 32'(SETS));
        check("b2b_hits", 32'(lkp_hit), 32'(SETS));

        // Invalidate right after a lookup accept.
        step(1, 0, 4'd2, 22'(2 * 32'h11111 + 5), 0, 0);
        ready_low = 0;
        step(1, 0, 4'd4, 22'h0, 0, 1);
        check("inv_resp_hit", 32'(bus.resp_hit), 32'(1));
        for (int i = 0; i < SETS; i++) step(1, 0, 4'(i), 22'h0, 0, (i == 3) ? 1'b1 : 1'b0);
        check("inv_ready_low", 32'(ready_low), 32'(SETS + 1));
        lkp_resp = 0; lkp_hit = 0;
        for (int i = 0; i < SETS; i++) begin
            step(1, 0, 4'(i), 22'(i * 32'h11111 + 5), 0, 0);
            if (i == 0) check("inv_ready_back", 32'(bus.req_ready), 32'(1));
        end
        step(0, 0, 4'd0, 22'h0, 0, 0);
        check("inv_all_miss_pulses", 32'(lkp_resp), 32'(SETS));
        check("inv_all_miss_hits", 32'(lkp_hit), 32'(0));

        // Reset while the sweep counter is at 7.
        step(0, 0, 4'd0, 22'h0, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 4'd0, 22'h0, 0, 0);
        check("midsweep_addr", 32'(sram_addr), 32'(6));
        do_reset(2);
        step(1, 0, 4'd1, 22'h0, 0, 0);
        if (INIT_SWEEP) begin
            check("restart_addr", 32'(sram_addr), 32'(0));
            check("restart_busy", 32'(busy), 32'(1));
        end else begin
            check("reset_to_run", 32'(bus.req_ready), 32'(1));
        end

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset(2);
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, SETS - 1)), pool[$urandom_range(0, 3)],
                 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < SETS + 2; i++) step(0, 0, 4'd0, 22'h0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
